timestamp_capture: RTL and testbench

TIMESTAMP_CAPTURE -- requirements
Module: timestamp_capture

---
 rtl/timestamp_capture.sv | 100 ++++++++++
 tb/tb_timestamp_capture.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/timestamp_capture.sv
// Event timestamp capture: synchronizes an async event, stamps it with
// a free-running count and queues the stamps in a small FIFO.
module timestamp_capture #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [WIDTH:0] count_in,
    input  logic           evt_in,
    output logic [WIDTH:0] ts_data,
    output logic           ts_valid,
    input  logic           ts_ready,
    input  logic           clr_ovf,
    output logic           overflow,
    output logic [7:0]     drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic           s1;
    logic           s2;
    logic           s3;
    logic [AW:0]    wptr;
    logic [AW:0]    rptr;
    logic [AW:0]    rptr_n;
    logic [WIDTH:0] mem [DEPTH];
    logic           detect;
    logic           full;
    logic           pop;
    logic           push;
    logic           drop;
    logic           valid_n;

    assign detect = s2 & ~s3;
    assign full   = (wptr[AW] != rptr[AW]) &&
                    (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop    = ts_valid & ts_ready;
    assign push   = detect & (~full | pop);
    assign drop   = detect & full & ~pop;
    assign rptr_n = rptr + {{AW{1'b0}}, pop};
    // Head view lags the write by one edge; no write-to-read bypass.
    assign valid_n = (wptr != rptr_n);

    // s1/s2 resolve metastability; s3 remembers the previous level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= evt_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + {{AW{1'b0}}, push};
            rptr <= rptr_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= count_in;
        end
    end

    // Under full+pop the write lands in the slot being freed, never rptr_n.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_valid <= 1'b0;
            ts_data  <= '0;
        end else begin
            ts_valid <= valid_n;
            ts_data  <= valid_n ? mem[rptr_n[AW-1:0]] : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (clr_ovf) begin
            overflow <= drop;
            drop_cnt <= {7'd0, drop};
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_timestamp_capture.sv
// Scoreboard bench for timestamp_capture: expected stamps are queued
// as events are driven and compared as entries are popped.
module tb_timestamp_capture;

    logic        clk;
    logic        reset;
    logic [30:0] count_in;
    logic        evt_in;
    logic [30:0] ts_data;
    logic        ts_valid;
    logic        ts_ready;
    logic        clr_ovf;
    logic        overflow;
    logic [7:0]  drop_cnt;

    logic [30:0] sb[$];
    int          n_cmp;
    int          n_bad;
    int          vcnt;

    timestamp_capture #(.WIDTH(30), .DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .count_in (count_in),
        .evt_in   (evt_in),
        .ts_data  (ts_data),
        .ts_valid (ts_valid),
        .ts_ready (ts_ready),
        .clr_ovf  (clr_ovf),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
        count_in = count_in + 31'd1;
    endtask

    // Stamp is the count seen two edges after the one that sees evt_in.
    task automatic pulse(input bit keep);
        evt_in = 1'b1;
        if (keep) sb.push_back(count_in + 31'd2);
        tick();
        evt_in = 1'b0;
        tick();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        ts_ready = 1'b1;
        while ((sb.size() != 0 || ts_valid) && n < 100) begin
            tick();
            n++;
        end
        chk(tag, sb.size(), 0);
        repeat (4) tick();
        ts_ready = 1'b0;
    endtask

    // Sample just before the next rising edge decides a pop.
    always @(negedge clk) begin
        #2;
        if (reset && ts_valid) begin
            vcnt++;
            if (ts_ready) begin
                chk("pop_avail", sb.size() > 0, 1);
                if (sb.size() > 0) chk("ts_data", ts_data, sb.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        vcnt     = 0;
        reset    = 1'b0;
        count_in = '0;
        evt_in   = 1'b0;
        ts_ready = 1'b0;
        clr_ovf  = 1'b0;
        repeat (3) tick();
        chk("rst_valid", ts_valid, 0);
        chk("rst_data", ts_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_cnt, 0);
        reset = 1'b1;
        repeat (3) tick();

        // single event at count 100 -> stamp 102
        ts_ready = 1'b1;
        vcnt = 0;
        count_in = 31'd99;
        tick();
        evt_in = 1'b1;
        sb.push_back(31'd102);
        tick();
        evt_in = 1'b0;
        drain("t1_drain");
        chk("t1_vcycles", vcnt, 1);

        // backpressure: 10,20,30,40
        ts_ready = 1'b0;
        count_in = 31'd8;
        for (int i = 0; i < 4; i++) begin
            while (count_in != 31'(8 + 10 * i)) tick();
            pulse(1'b1);
        end
        repeat (3) tick();
        chk("t2_valid", ts_valid, 1);
        chk("t2_head", ts_data, 10);
        drain("t2_drain");
        chk("t2_ovf", overflow, 0);

        // overflow: 6 events into depth 4
        for (int i = 0; i < 6; i++) pulse(i < 4);
        repeat (3) tick();
        chk("t3_ovf", overflow, 1);
        chk("t3_drop", drop_cnt, 2);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t3_clr_ovf", overflow, 0);
        chk("t3_clr_drop", drop_cnt, 0);
        drain("t3_drain");

        // full plus pop in the write cycle
        for (int i = 0; i < 4; i++) pulse(1'b1);
        repeat (3) tick();
        evt_in = 1'b1;
        sb.push_back(count_in + 31'd2);
        tick();
        evt_in = 1'b0;
        tick();
        ts_ready = 1'b1;
        tick();
        ts_ready = 1'b0;
        repeat (2) tick();
        chk("t4_drop0", drop_cnt, 0);
        chk("t4_ovf0", overflow, 0);
        pulse(1'b0);
        repeat (3) tick();
        chk("t4_still_full", drop_cnt, 1);
        chk("t4_ovf1", overflow, 1);
        drain("t4_drain");

        // saturation, then drop with clear
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        for (int i = 0; i < 4; i++) pulse(1'b1);
        for (int i = 0; i < 300; i++) pulse(1'b0);
        repeat (3) tick();
        chk("t5_sat", drop_cnt, 255);
        chk("t5_ovf", overflow, 1);
        evt_in = 1'b1;
        tick();
        evt_in = 1'b0;
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t5_clr_drop", drop_cnt, 1);
        chk("t5_clr_ovf", overflow, 1);
        drain("t5_drain");

        // asynchronous reset mid-run with 3 entries held
        for (int i = 0; i < 3; i++) pulse(1'b1);
        repeat (3) tick();
        chk("t6_pre_valid", ts_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_valid", ts_valid, 0);
        chk("t6_async_data", ts_data, 0);
        sb.delete();
        evt_in = 1'b1;
        tick();
        tick();
        #2;
        reset = 1'b1;
        sb.push_back(count_in + 31'd2);
        drain("t6_drain");
        evt_in = 1'b0;
        repeat (4) tick();
        chk("t6_empty", ts_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
